// File: rtl/sal_bk_timer_pkg.sv
// Shared types and widths for the per-bank DRAM timing tracker.
package sal_bk_timer_pkg;

  localparam int CNT_W  = 8;
  localparam int MAIN_W = 10;
  localparam int RA_W   = 16;

  typedef enum logic [2:0] {
    ST_CLOSED,
    ST_OPENING,
    ST_CLOSING,
    ST_OPEN,
    ST_REFRESHING
  } bank_state_t;

endpackage

// File: rtl/sal_tcnt.sv
// Loadable down-counter that saturates at zero and flags it.
module sal_tcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sal_bk_timer.sv
// Per-bank timing legality tracker: state, timing counters,
// row-open timeout and sticky protocol error.
module sal_bk_timer
  import sal_bk_timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  t_rcd_m1,
  input  logic [CNT_W-1:0]  t_rp_m1,
  input  logic [CNT_W-1:0]  t_ras_m1,
  input  logic [CNT_W-1:0]  t_rc_m1,
  input  logic [CNT_W-1:0]  t_rtp_m1,
  input  logic [CNT_W-1:0]  t_wtp_m1,
  input  logic [MAIN_W-1:0] t_rfc_m1,
  input  logic [CNT_W-1:0]  row_open_cnt,
  input  logic              act_gnt,
  input  logic              rd_gnt,
  input  logic              wr_gnt,
  input  logic              pre_gnt,
  input  logic              ref_gnt,
  input  logic [RA_W-1:0]   act_ra,
  output logic              act_ok,
  output logic              rd_ok,
  output logic              wr_ok,
  output logic              pre_ok,
  output logic              ref_ok,
  output logic              is_open,
  output logic [RA_W-1:0]   cur_ra,
  output logic              auto_pre_req,
  output logic              err
);

  bank_state_t st, st_nx;

  logic [MAIN_W-1:0] main_cnt, main_val;
  logic [CNT_W-1:0]  ras_cnt, rc_cnt, rtp_cnt, wtp_cnt;
  logic [CNT_W-1:0]  idle_cnt;
  logic main_z, ras_z, rc_z, rtp_z, wtp_z;
  logic [4:0] gv;
  logic multi, ready, shut_ok;
  logic act_go, rd_go, wr_go, pre_go, ref_go, bad;

  // Grants are only legal alone; any illegal or colliding grant is dropped.
  assign gv     = {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt};
  assign multi  = ($countones(gv) > 1);
  assign act_go = act_gnt & act_ok & ~multi;
  assign rd_go  = rd_gnt  & rd_ok  & ~multi;
  assign wr_go  = wr_gnt  & wr_ok  & ~multi;
  assign pre_go = pre_gnt & pre_ok & ~multi;
  assign ref_go = ref_gnt & ref_ok & ~multi;
  assign bad    = (|gv) & ~(act_go | rd_go | wr_go | pre_go | ref_go);

  assign ready = (st == ST_OPEN) | ((st == ST_OPENING) & main_z);
  // Closing and refresh are both finished once the main count expires.
  assign shut_ok = (st == ST_CLOSED) |
                   (((st == ST_CLOSING) | (st == ST_REFRESHING)) & main_z);

  assign act_ok  = shut_ok & rc_z;
  assign ref_ok  = shut_ok;
  assign rd_ok   = ready;
  assign wr_ok   = ready;
  assign pre_ok  = ready & ras_z & rtp_z & wtp_z;
  assign is_open = (st == ST_OPENING) | (st == ST_OPEN) |
                   (st == ST_CLOSING);
  assign auto_pre_req = (st == ST_OPEN) & (idle_cnt >= row_open_cnt);

  always_comb begin
    main_val = t_rfc_m1;
    if (act_go)
      main_val = MAIN_W'(t_rcd_m1);
    else if (pre_go)
      main_val = MAIN_W'(t_rp_m1);
  end

  sal_tcnt #(.W(MAIN_W)) u_main (
    .clk(clk), .rst(rst), .load(act_go | pre_go | ref_go),
    .load_val(main_val), .cnt(main_cnt), .zero(main_z)
  );
  sal_tcnt #(.W(CNT_W)) u_ras (
    .clk(clk), .rst(rst), .load(act_go),
    .load_val(t_ras_m1), .cnt(ras_cnt), .zero(ras_z)
  );
  sal_tcnt #(.W(CNT_W)) u_rc (
    .clk(clk), .rst(rst), .load(act_go),
    .load_val(t_rc_m1), .cnt(rc_cnt), .zero(rc_z)
  );
  sal_tcnt #(.W(CNT_W)) u_rtp (
    .clk(clk), .rst(rst), .load(rd_go),
    .load_val(t_rtp_m1), .cnt(rtp_cnt), .zero(rtp_z)
  );
  sal_tcnt #(.W(CNT_W)) u_wtp (
    .clk(clk), .rst(rst), .load(wr_go),
    .load_val(t_wtp_m1), .cnt(wtp_cnt), .zero(wtp_z)
  );

  always_comb begin
    st_nx = st;
    unique case (st)
      ST_CLOSED: begin
        if (act_go)
          st_nx = ST_OPENING;
        else if (ref_go)
          st_nx = ST_REFRESHING;
      end
      ST_OPENING: begin
        if (pre_go)
          st_nx = ST_CLOSING;
        else if (main_z)
          st_nx = ST_OPEN;
      end
      ST_OPEN: begin
        if (pre_go)
          st_nx = ST_CLOSING;
      end
      ST_CLOSING, ST_REFRESHING: begin
        if (act_go)
          st_nx = ST_OPENING;
        else if (ref_go)
          st_nx = ST_REFRESHING;
        else if (main_z)
          st_nx = ST_CLOSED;
      end
      default: st_nx = ST_CLOSED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_CLOSED;
      cur_ra   <= '0;
      err      <= 1'b0;
      idle_cnt <= '0;
    end else begin
      st  <= st_nx;
      err <= err | bad;
      if (act_go)
        cur_ra <= act_ra;
      if ((st != ST_OPEN) | rd_go | wr_go)
        idle_cnt <= '0;
      else if (idle_cnt != '1)
        idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sal_bk_timer.sv
// Directed scoreboard bench for sal_bk_timer.
module tb_sal_bk_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] t_rcd_m1, t_rp_m1, t_ras_m1, t_rc_m1;
  logic [7:0] t_rtp_m1, t_wtp_m1, row_open_cnt;
  logic [9:0] t_rfc_m1;
  logic       act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic [15:0] act_ra;
  logic       act_ok, rd_ok, wr_ok, pre_ok, ref_ok;
  logic       is_open, auto_pre_req, err;
  logic [15:0] cur_ra;

  sal_bk_timer dut (
    .clk(clk), .rst(rst),
    .t_rcd_m1(t_rcd_m1), .t_rp_m1(t_rp_m1),
    .t_ras_m1(t_ras_m1), .t_rc_m1(t_rc_m1),
    .t_rtp_m1(t_rtp_m1), .t_wtp_m1(t_wtp_m1),
    .t_rfc_m1(t_rfc_m1), .row_open_cnt(row_open_cnt),
    .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
    .pre_gnt(pre_gnt), .ref_gnt(ref_gnt), .act_ra(act_ra),
    .act_ok(act_ok), .rd_ok(rd_ok), .wr_ok(wr_ok),
    .pre_ok(pre_ok), .ref_ok(ref_ok), .is_open(is_open),
    .cur_ra(cur_ra), .auto_pre_req(auto_pre_req), .err(err)
  );

  always #5 clk = ~clk;

  localparam int S_ACT = 0, S_RD = 1, S_WR = 2, S_PRE = 3;
  localparam int S_REF = 4, S_OPN = 5, S_AUTO = 6, S_ERR = 7;
  localparam int S_RA = 8;

  typedef struct {
    int          cyc;
    int          sig;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t em;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  function automatic string sname(input int id);
    case (id)
      S_ACT:  return "act_ok";
      S_RD:   return "rd_ok";
      S_WR:   return "wr_ok";
      S_PRE:  return "pre_ok";
      S_REF:  return "ref_ok";
      S_OPN:  return "is_open";
      S_AUTO: return "auto_pre_req";
      S_ERR:  return "err";
      default: return "cur_ra";
    endcase
  endfunction

  function automatic logic [15:0] probe(input int id);
    case (id)
      S_ACT:  return {15'd0, act_ok};
      S_RD:   return {15'd0, rd_ok};
      S_WR:   return {15'd0, wr_ok};
      S_PRE:  return {15'd0, pre_ok};
      S_REF:  return {15'd0, ref_ok};
      S_OPN:  return {15'd0, is_open};
      S_AUTO: return {15'd0, auto_pre_req};
      S_ERR:  return {15'd0, err};
      default: return cur_ra;
    endcase
  endfunction

  function automatic void expect_at(input int c, input int id,
                                    input logic [15:0] v);
    exp_t e;
    e.cyc = c;
    e.sig = id;
    e.val = v;
    sb.push_back(e);
  endfunction

  // Monitor: retire every expectation due in the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      em = sb.pop_front();
      total++;
      if (em.cyc != cyc) begin
        bad++;
        $display("FAIL %s stale c=%0d now=%0d", sname(em.sig),
                 em.cyc, cyc);
      end else if (probe(em.sig) !== em.val) begin
        bad++;
        $display("FAIL %s c=%0d got=%h want=%h", sname(em.sig),
                 cyc, probe(em.sig), em.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic grant(input int kind, input logic [15:0] ra);
    act_gnt = (kind == S_ACT);
    rd_gnt  = (kind == S_RD);
    wr_gnt  = (kind == S_WR);
    pre_gnt = (kind == S_PRE);
    ref_gnt = (kind == S_REF);
    act_ra  = ra;
    tick();
    {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt} = '0;
  endtask

  int b;

  initial begin
    rst = 1'b1;
    {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt} = '0;
    act_ra = '0;
    t_rcd_m1 = 8'd3;  t_rp_m1 = 8'd2;  t_ras_m1 = 8'd9;
    t_rc_m1  = 8'd14; t_rtp_m1 = 8'd2; t_wtp_m1 = 8'd4;
    t_rfc_m1 = 10'd99; row_open_cnt = 8'd5;

    // reset values
    b = cyc;
    expect_at(b+1, S_ACT, 1);  expect_at(b+1, S_REF, 1);
    expect_at(b+1, S_RD, 0);   expect_at(b+1, S_WR, 0);
    expect_at(b+1, S_PRE, 0);  expect_at(b+1, S_OPN, 0);
    expect_at(b+1, S_AUTO, 0); expect_at(b+1, S_ERR, 0);
    expect_at(b+1, S_RA, 0);
    tick();
    rst = 1'b0;
    idle(2);

    // ACT -> tRCD, RD late -> tRTP-limited PRE, tRC on reopen
    b = cyc;
    expect_at(b, S_ACT, 1); expect_at(b, S_RD, 0); expect_at(b, S_OPN, 0);
    expect_at(b+1, S_RD, 0); expect_at(b+1, S_OPN, 1);
    expect_at(b+1, S_RA, 16'h1234);
    expect_at(b+2, S_RD, 0); expect_at(b+3, S_RD, 0);
    expect_at(b+4, S_RD, 1);
    expect_at(b+9, S_AUTO, 0);
    expect_at(b+11, S_PRE, 0); expect_at(b+12, S_PRE, 1);
    expect_at(b+15, S_ACT, 1); expect_at(b+15, S_OPN, 1);
    expect_at(b+16, S_OPN, 0);
    grant(S_ACT, 16'h1234);
    idle(8);
    grant(S_RD, 0);
    idle(2);
    grant(S_PRE, 0);
    idle(6);

    // early RD -> tRAS-limited PRE, tRC blocks ACT through c14
    b = cyc;
    expect_at(b+1, S_RA, 16'hBEEF);
    expect_at(b+4, S_RD, 1);
    expect_at(b+9, S_PRE, 0); expect_at(b+10, S_PRE, 1);
    expect_at(b+13, S_REF, 1); expect_at(b+13, S_ACT, 0);
    expect_at(b+14, S_ACT, 0); expect_at(b+15, S_ACT, 1);
    grant(S_ACT, 16'hBEEF);
    idle(3);
    grant(S_RD, 0);
    idle(5);
    grant(S_PRE, 0);
    idle(7);

    // row-open timeout, cleared by RD
    b = cyc;
    expect_at(b+9, S_AUTO, 0); expect_at(b+10, S_AUTO, 1);
    expect_at(b+11, S_AUTO, 1); expect_at(b+11, S_WR, 1);
    expect_at(b+12, S_AUTO, 0); expect_at(b+14, S_PRE, 1);
    grant(S_ACT, 16'h00A5);
    idle(10);
    grant(S_RD, 0);
    idle(2);
    grant(S_PRE, 0);
    idle(6);

    // refresh
    b = cyc;
    expect_at(b, S_REF, 1);
    expect_at(b+1, S_ACT, 0); expect_at(b+1, S_REF, 0);
    expect_at(b+50, S_OPN, 0);
    expect_at(b+99, S_ACT, 0); expect_at(b+99, S_REF, 0);
    expect_at(b+100, S_ACT, 1); expect_at(b+100, S_REF, 1);
    expect_at(b+101, S_ACT, 1);
    grant(S_REF, 0);
    idle(102);

    // illegal RD, reset during refresh, colliding grants
    b = cyc;
    expect_at(b, S_ERR, 0);
    expect_at(b+1, S_ERR, 1); expect_at(b+1, S_ACT, 1);
    expect_at(b+1, S_OPN, 0);
    expect_at(b+3, S_ACT, 0); expect_at(b+4, S_ERR, 1);
    expect_at(b+6, S_ACT, 1); expect_at(b+6, S_REF, 1);
    expect_at(b+6, S_ERR, 0); expect_at(b+6, S_RA, 0);
    expect_at(b+6, S_OPN, 0); expect_at(b+7, S_ACT, 1);
    expect_at(b+9, S_ERR, 1); expect_at(b+9, S_ACT, 1);
    expect_at(b+9, S_OPN, 0);
    grant(S_RD, 0);
    idle(1);
    grant(S_REF, 0);
    idle(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(2);
    act_gnt = 1'b1;
    ref_gnt = 1'b1;
    tick();
    {act_gnt, ref_gnt} = '0;
    idle(3);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
